// File: rtl/delta_pkg.sv
// Shared types and elaboration-time helpers for the steering-delay generators.
// Mic coordinates are expressed in half-pitch units so they stay integral.
package delta_pkg;

   typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

   // Projection width: coordinate width, plus growth from the largest mic
   // coordinate, plus room for the sum of the two products.
   function automatic int calc_r_w(input int coord_w, input int nx, input int ny);
      int m;
      m = (nx > ny) ? nx : ny;
      return coord_w + $clog2(m) + 2;
   endfunction

   function automatic int mic_mx(input int idx, input int nx);
      return 2 * (idx % nx) - (nx - 1);
   endfunction

   function automatic int mic_my(input int idx, input int nx, input int ny);
      return 2 * (idx / nx) - (ny - 1);
   endfunction

endpackage

// File: rtl/delta_norm_sat.sv
// Normalise one projection against the array minimum, scale down by SHIFT
// and clip to the unsigned delay range.
module delta_norm_sat #(
   parameter int R_W     = 12,
   parameter int SHIFT   = 2,
   parameter int DELTA_W = 8
) (
   input  logic signed [R_W-1:0]   i_r,
   input  logic signed [R_W-1:0]   i_min,
   output logic        [DELTA_W-1:0] o_d
);

   localparam int WIDE = (R_W + 1 > DELTA_W) ? R_W + 1 : DELTA_W;
   localparam logic [WIDE-1:0] SAT_MAX = WIDE'({DELTA_W{1'b1}});

   logic [R_W:0]    w_diff;
   logic [R_W:0]    w_shr;
   logic [WIDE-1:0] w_ext;

   // i_min never exceeds i_r, so the extended difference is non-negative.
   assign w_diff = {i_r[R_W-1], i_r} - {i_min[R_W-1], i_min};
   assign w_shr  = w_diff >> SHIFT;
   assign w_ext  = WIDE'(w_shr);
   assign o_d    = (w_ext > SAT_MAX) ? {DELTA_W{1'b1}} : w_ext[DELTA_W-1:0];

endmodule

// File: rtl/delta_generator_seq.sv
// Time-multiplexed steering-delay generator: one projection per cycle, then one
// normalised delay per cycle, then an atomic publish of all channels.
module delta_generator_seq
   import delta_pkg::*;
#(
   parameter int NX      = 4,
   parameter int NY      = 4,
   parameter int COORD_W = 8,
   parameter int DELTA_W = 8,
   parameter int SHIFT   = 2,
   parameter int R_W     = calc_r_w(COORD_W, NX, NY)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic signed [COORD_W-1:0] p_x,
   input  logic signed [COORD_W-1:0] p_y,
   output logic                      o_busy,
   output logic                      o_valid,
   output logic        [DELTA_W-1:0] delta [NX*NY]
);

   localparam int N_CH  = NX * NY;
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_CH - 1);
   localparam logic signed [R_W-1:0] MIN_INIT = {1'b0, {(R_W-1){1'b1}}};

   state_t                    r_state;
   logic [IDX_W-1:0]          r_idx;
   logic signed [COORD_W-1:0] r_px;
   logic signed [COORD_W-1:0] r_py;
   logic signed [R_W-1:0]     r_min;
   logic signed [R_W-1:0]     r_proj   [N_CH];
   logic [DELTA_W-1:0]        r_shadow [N_CH];
   logic [DELTA_W-1:0]        r_delta  [N_CH];
   logic                      r_busy;
   logic                      r_valid;

   logic signed [R_W-1:0]     w_mx [N_CH];
   logic signed [R_W-1:0]     w_my [N_CH];
   logic signed [R_W-1:0]     w_px_ext;
   logic signed [R_W-1:0]     w_py_ext;
   logic signed [R_W-1:0]     w_proj;
   logic [DELTA_W-1:0]        w_d;

   // Per-mic coordinate constants; the multiplies below collapse to shifts/adds.
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         assign w_mx[gi]  = R_W'(mic_mx(gi, NX));
         assign w_my[gi]  = R_W'(mic_my(gi, NX, NY));
         assign delta[gi] = r_delta[gi];
      end
   endgenerate

   assign w_px_ext = R_W'(r_px);
   assign w_py_ext = R_W'(r_py);
   assign w_proj   = w_mx[r_idx] * w_px_ext + w_my[r_idx] * w_py_ext;

   delta_norm_sat #(
      .R_W     (R_W),
      .SHIFT   (SHIFT),
      .DELTA_W (DELTA_W)
   ) u_norm (
      .i_r   (r_proj[r_idx]),
      .i_min (r_min),
      .o_d   (w_d)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_px    <= '0;
         r_py    <= '0;
         r_min   <= MIN_INIT;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_proj[i]   <= '0;
            r_shadow[i] <= '0;
            r_delta[i]  <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (i_start) begin
                  r_px    <= p_x;
                  r_py    <= p_y;
                  r_idx   <= '0;
                  r_min   <= MIN_INIT;
                  r_busy  <= 1'b1;
                  r_state <= ACC;
               end
            end
            ACC: begin
               r_proj[r_idx] <= w_proj;
               if (w_proj < r_min) r_min <= w_proj;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= NORM;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            NORM: begin
               r_shadow[r_idx] <= w_d;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               // Publish every channel on the same edge so readers never see a mix.
               for (int i = 0; i < N_CH; i++) r_delta[i] <= r_shadow[i];
               r_valid <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_delta_generator_seq.sv
// Directed and randomised checks of delta_generator_seq (default 4x4 and an 8x2
// variant) against an arithmetic model of the steering delays.
module tb_delta_generator_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              start_a, start_b;
   logic signed [7:0] px_a, py_a, px_b, py_b;
   logic              busy_a, valid_a, busy_b, valid_b;
   logic [7:0]        delta_a [16];
   logic [9:0]        delta_b [16];

   int n_assert = 0;
   int n_fail   = 0;
   int exp_d [16];

   delta_generator_seq dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a), .p_x(px_a), .p_y(py_a),
      .o_busy(busy_a), .o_valid(valid_a), .delta(delta_a)
   );

   delta_generator_seq #(.NX(8), .NY(2), .SHIFT(0), .DELTA_W(10)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b), .p_x(px_b), .p_y(py_b),
      .o_busy(busy_b), .o_valid(valid_b), .delta(delta_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Delays from the geometry: projection on half-pitch mic positions,
   // shift so the earliest mic is zero, scale, clip.
   task automatic model(input int sel, input int px, input int py);
      int nx, ny, sh, dmax, mn, d;
      int r [16];
      nx = sel ? 8 : 4; ny = sel ? 2 : 4; sh = sel ? 0 : 2; dmax = sel ? 1023 : 255;
      mn = 1 << 30;
      for (int i = 0; i < 16; i++) begin
         r[i] = (2 * (i % nx) - (nx - 1)) * px + (2 * (i / nx) - (ny - 1)) * py;
         if (r[i] < mn) mn = r[i];
      end
      for (int i = 0; i < 16; i++) begin
         d = (r[i] - mn) / (1 << sh);
         exp_d[i] = (d > dmax) ? dmax : d;
      end
   endtask

   task automatic set_in(input int sel, input logic s, input int px, input int py);
      if (sel != 0) begin start_b = s; px_b = px[7:0]; py_b = py[7:0]; end
      else          begin start_a = s; px_a = px[7:0]; py_a = py[7:0]; end
   endtask

   function automatic logic [31:0] g_valid(input int sel);
      return (sel != 0) ? {31'b0, valid_b} : {31'b0, valid_a};
   endfunction

   function automatic logic [31:0] g_busy(input int sel);
      return (sel != 0) ? {31'b0, busy_b} : {31'b0, busy_a};
   endfunction

   function automatic logic [31:0] g_delta(input int sel, input int i);
      return (sel != 0) ? {22'b0, delta_b[i]} : {24'b0, delta_a[i]};
   endfunction

   function automatic int rnd_coord();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // One job: accept, scramble inputs, measure latency, check all channels,
   // optionally poke i_start mid-job and confirm it is ignored.
   task automatic run_job(input int sel, input int px, input int py, input bit pulses,
                          input string tag);
      int cyc, lat, nvalid, last;
      bit unstable;
      model(sel, px, py);
      @(negedge clk); set_in(sel, 1'b1, px, py);
      @(posedge clk); #1;
      chk({tag, "/busy_accept"}, g_busy(sel), 1);
      set_in(sel, 1'b0, rnd_coord(), rnd_coord());
      cyc = 0; lat = -1; nvalid = 0; unstable = 0;
      last = pulses ? 75 : 35;
      while (cyc < last) begin
         @(posedge clk); #1;
         cyc++;
         if (pulses && (cyc == 4 || cyc == 19)) set_in(sel, 1'b1, rnd_coord(), rnd_coord());
         if (pulses && (cyc == 5 || cyc == 20)) set_in(sel, 1'b0, rnd_coord(), rnd_coord());
         if (g_valid(sel) == 1) begin
            nvalid++;
            if (lat < 0) begin
               lat = cyc;
               chk({tag, "/busy_at_valid"}, g_busy(sel), 1);
               for (int i = 0; i < 16; i++)
                  chk($sformatf("%s/delta[%0d]", tag, i), g_delta(sel, i), exp_d[i]);
            end
         end else if (lat > 0) begin
            for (int i = 0; i < 16; i++)
               if (g_delta(sel, i) !== exp_d[i]) unstable = 1;
         end
         if (cyc == 34) chk({tag, "/busy_drop"}, g_busy(sel), 0);
      end
      chk({tag, "/latency"}, lat, 33);
      chk({tag, "/valid_count"}, nvalid, 1);
      chk({tag, "/delta_stable"}, {31'b0, unstable}, 0);
   endtask

   initial begin
      int cyc, nvalid;
      int vq [$];
      bit unstable;

      rst = 1'b1;
      set_in(0, 1'b0, 0, 0);
      set_in(1, 1'b0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy_a", g_busy(0), 0);
      chk("reset/valid_a", g_valid(0), 0);
      chk("reset/busy_b", g_busy(1), 0);
      chk("reset/valid_b", g_valid(1), 0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("reset/delta_a[%0d]", i), g_delta(0, i), 0);
         chk($sformatf("reset/delta_b[%0d]", i), g_delta(1, i), 0);
      end
      @(negedge clk); rst = 1'b0;

      // Abort: reset sampled at accept+10 must discard the job.
      @(negedge clk); set_in(0, 1'b1, 3, -26);
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 45; c++) begin
         @(posedge clk); #1;
         if (valid_a) nvalid++;
      end
      chk("abort/valid_count", nvalid, 0);
      chk("abort/busy", g_busy(0), 0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("abort/delta[%0d]", i), g_delta(0, i), 0);

      run_job(0, 3, -26, 1'b0, "nominal");
      chk("nominal/d12", g_delta(0, 12), 0);
      chk("nominal/d3", g_delta(0, 3), 43);
      chk("nominal/d0", g_delta(0, 0), 39);

      run_job(0, -128, 127, 1'b0, "saturate");
      chk("saturate/d12", g_delta(0, 12), 255);
      chk("saturate/d3", g_delta(0, 3), 0);
      chk("saturate/d0", g_delta(0, 0), 192);

      run_job(0, 0, 0, 1'b0, "zero");
      run_job(0, 17, 5, 1'b1, "ignore_start");

      // i_start held high: back-to-back jobs every 2*N_CH+2 cycles.
      model(0, -50, 77);
      @(negedge clk); set_in(0, 1'b1, -50, 77);
      @(posedge clk); #1;
      cyc = 0; unstable = 0;
      while (cyc < 110) begin
         @(posedge clk); #1;
         cyc++;
         if (valid_a) vq.push_back(cyc);
         else if (vq.size() > 0)
            for (int i = 0; i < 16; i++)
               if (g_delta(0, i) !== exp_d[i]) unstable = 1;
         if (cyc == 101) start_a = 1'b0;
         if (cyc == 102) chk("held/busy_drop", g_busy(0), 0);
      end
      chk("held/valid_count", vq.size(), 3);
      chk("held/valid0", (vq.size() > 0) ? vq[0] : -1, 33);
      chk("held/valid1", (vq.size() > 1) ? vq[1] : -1, 67);
      chk("held/valid2", (vq.size() > 2) ? vq[2] : -1, 101);
      chk("held/delta_stable", {31'b0, unstable}, 0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("held/delta[%0d]", i), g_delta(0, i), exp_d[i]);

      for (int n = 0; n < 20; n++)
         run_job(0, rnd_coord(), rnd_coord(), 1'b0, $sformatf("rand_a%0d", n));
      for (int n = 0; n < 200; n++)
         run_job(1, rnd_coord(), rnd_coord(), 1'b0, $sformatf("rand_b%0d", n));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/delta_generator_seq.md
# delta_generator_seq

Parametrised, time-multiplexed steering-delay generator for an NX×NY microphone array. A focus direction (p_x, p_y) is accepted with a start/busy/valid handshake. One signed projection per mic is computed per cycle, the minimum is tracked, and all delays are normalised so the earliest mic gets 0. The result is published atomically to the delay-and-sum beamformer. It replaces the fixed 16-channel combinational generator and adds:
- arbitrary array size
- shift scaling
- saturation
- explicit completion signalling

## Interface
Parameters:
- NX, 4, mic columns
- NY, 4, mic rows; N_CH = NX*NY
- COORD_W, 8, signed width of p_x/p_y
- DELTA_W, 8, unsigned delay width
- SHIFT, 2, right-shift applied to normalised projection
- R_W, COORD_W+$clog2(max(NX,NY))+2, internal signed projection width (derived)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  request; accepted only in IDLE
- p_x  in  COORD_W  signed x steering component, sampled on accept
- p_y  in  COORD_W  signed y steering component, sampled on accept
- o_busy  out  1  high from the cycle after accept until o_valid cycle inclusive
- o_valid  out  1  one-cycle pulse: delta just updated
- delta  out  DELTA_W × N_CH  unpacked array, delta[i] for mic i; holds last result

## Operation
- Mic i: column c = i % NX, row r = i / NX.
- Mic coordinates are in half-pitch units: mx = 2c-(NX-1), my = 2r-(NY-1). Both are small signed constants.
- Projection: r_i = mx*p_x + my*p_y, signed, full precision in R_W bits (no overflow possible).
- FSM states:
  - IDLE: i_start=1 → latch p_x, p_y; clear index and min (to most-positive R_W value) → ACC.
  - ACC: each cycle compute r_idx, store it in the projection buffer, and update the running min (strict less-than) → NORM after index N_CH-1, index reset to 0.
  - NORM: each cycle compute d = (r_idx - min) >> SHIFT, unsigned.
    - If d > 2^DELTA_W-1, saturate to 2^DELTA_W-1.
    - Write d into the shadow buffer.
    - → DONE after index N_CH-1.
  - DONE: copy shadow → delta (all channels same edge), assert o_valid → IDLE.
- i_start while not IDLE is ignored (no queueing). p_x/p_y changes after accept have no effect.
- delta changes only on the DONE edge; intermediate values never visible.
- Reset value of every output:
  - o_busy = 0
  - o_valid = 0
  - delta[i] = 0 for all i
  - FSM = IDLE, buffers cleared
- Reset mid-operation aborts the job. The pending result is discarded and no o_valid is issued.

## Timing
- Accept edge k: i_start high in IDLE sampled at edge k.
- o_busy high from edge k.
- ACC occupies N_CH cycles; NORM occupies N_CH cycles.
- DONE edge at k+2·N_CH+1: delta updated and o_valid high for exactly that cycle; o_busy drops at the next edge.
- Default latency is 33 cycles accept→o_valid.
- Back-to-back: i_start may be high in the cycle o_valid is high. It is accepted on the following edge (first edge in IDLE), so the minimum period is 2·N_CH+2 cycles.
- The min compare and buffer write in ACC are single-cycle. The NORM subtract, shift and saturate is single-cycle; there are no multicycle paths.

## Structure
- Shared package delta_pkg holds:
  - the state enum (IDLE, ACC, NORM, DONE)
  - the mic-coordinate function (index → mx, my)
  - the R_W derivation helper
- One sub-module, delta_norm_sat, does the combinational subtract, shift and saturate. It is parametrised by R_W, SHIFT and DELTA_W, and is reusable by the planned 3-D (near-field) variant.
- Multipliers by the small constants mx, my are implemented as generic signed multiplies. Synthesis reduces them.

## Test plan
- Reset: hold i_rst 3 cycles → all delta = 0, o_busy = 0, o_valid = 0.
  - Start, then assert i_rst at accept+10 → no o_valid, delta stays 0, FSM in IDLE.
- Nominal p_x=3, p_y=-26, defaults → o_valid exactly 33 cycles after accept.
  - delta[12]=0, delta[3]=43, delta[0]=39; all others match the reference model.
- Saturation p_x=-128, p_y=127 → delta[12]=255 (raw 382 clipped), delta[3]=0, delta[0]=192.
- Zero direction p_x=0, p_y=0 → all delta = 0, o_valid pulses once.
- Handshake:
  - i_start pulsed at accept+5 and accept+20 → ignored, exactly one o_valid.
  - i_start held high continuously → o_valid every 34 cycles.
  - delta constant between pulses.
- Parametrisation: NX=8, NY=2, SHIFT=0, DELTA_W=10, random p_x/p_y (200 runs) → matches the model, latency 33 cycles.
